// File: rtl/fns_enc_seq.sv
// Sequential Fibonacci-numeral encoder. Each CONV cycle handles one wire, MSB
// first, and does a greedy subtract against that wire's weight.
module fns_enc_seq #(
    parameter int CODE_W = 9,
    parameter int DATA_W = 6,
    parameter int FNS_W  = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CODE_W-1:0]             en_flag,
    input  logic [(CODE_W-2)*FNS_W-1:0]   fns_w,
    output logic [CODE_W-1:0]             out_code,
    output logic                          out_err,
    output logic                          out_valid,
    input  logic                          out_ready
);
    localparam int IDX_W = $clog2(CODE_W);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t                           state_q, state_d;
    logic [FNS_W-1:0]                 res_q, res_d, res_nxt, cur_w;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [CODE_W-1:0]                code_q, code_d, en_q, en_d;
    logic [CODE_W-3:0][FNS_W-1:0]     w_q, w_d;
    logic                             err_q, err_d, cur_en, take;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
            idx_q   <= '0;
            code_q  <= '0;
            err_q   <= 1'b0;
            en_q    <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            err_q   <= err_d;
            en_q    <= en_d;
            w_q     <= w_d;
        end
    end

    // Wires 0 and 1 carry the fixed weight 1; the rest come from the snapshot.
    always_comb begin
        cur_w  = FNS_W'(1);
        cur_en = 1'b0;
        for (int k = 0; k < CODE_W; k++)
            if (idx_q == IDX_W'(k)) cur_en = en_q[k];
        for (int k = 2; k < CODE_W; k++)
            if (idx_q == IDX_W'(k)) cur_w = w_q[k-2];
        take    = cur_en && (res_q >= cur_w);
        res_nxt = take ? res_q - cur_w : res_q;
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        idx_d   = idx_q;
        code_d  = code_q;
        err_d   = err_q;
        en_d    = en_q;
        w_d     = w_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = CONV;
                res_d   = FNS_W'(in_data);
                en_d    = en_flag;
                w_d     = fns_w;
                code_d  = '0;
                err_d   = 1'b0;
                idx_d   = IDX_W'(CODE_W-1);
            end
            CONV: begin
                res_d = res_nxt;
                for (int k = 0; k < CODE_W; k++)
                    if (idx_q == IDX_W'(k)) code_d[k] = take;
                if (idx_q == '0) begin
                    state_d = DONE;
                    err_d   = (res_nxt != '0);
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_code  = code_q;
    assign out_err   = err_q;
endmodule

// File: tb/tb_fns_enc_seq.sv
// Directed and round-trip bench for the sequential FNS encoder.
module tb_fns_enc_seq;
    localparam int CODE_W = 9, DATA_W = 6, FNS_W = 7;
    localparam int WW = (CODE_W-2)*FNS_W;

    logic              clk = 1'b0, rst = 1'b1;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0, in_ready;
    logic [CODE_W-1:0] en_flag = '0;
    logic [WW-1:0]     fns_w = '0;
    logic [CODE_W-1:0] out_code;
    logic              out_err, out_valid;
    logic              out_ready = 1'b0;

    int passed = 0, total = 0;

    fns_enc_seq #(.CODE_W(CODE_W), .DATA_W(DATA_W), .FNS_W(FNS_W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .en_flag(en_flag), .fns_w(fns_w),
        .out_code(out_code), .out_err(out_err), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    localparam logic [WW-1:0] W_FIB  = {7'd34, 7'd21, 7'd13, 7'd8, 7'd5, 7'd3, 7'd2};
    localparam logic [WW-1:0] W_ZERO = {7'd34, 7'd21, 7'd13, 7'd8, 7'd5, 7'd3, 7'd0};
    localparam logic [WW-1:0] W_ALT  = {7'd55, 7'd34, 7'd21, 7'd13, 7'd8, 7'd5, 7'd3};

    typedef struct {
        string             name;
        logic [DATA_W-1:0] data;
        logic [CODE_W-1:0] en;
        logic [WW-1:0]     w;
        logic [CODE_W-1:0] exp_code;
        logic              exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accepts one word and waits for out_valid; lat counts edges after accept.
    task automatic encode(input logic [DATA_W-1:0] d, input logic [CODE_W-1:0] e,
                          input logic [WW-1:0] w, output int lat);
        int n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        in_data = d; en_flag = e; fns_w = w; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_data = ~d; en_flag = ~e; fns_w = ~w;   // must be ignored after accept
        lat = 0;
        while (!out_valid && lat < 30) begin step(); lat++; end
        if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    function automatic int decode(input logic [CODE_W-1:0] c, input logic [WW-1:0] w);
        int s = 0;
        if (c[0]) s += 1;
        if (c[1]) s += 1;
        for (int k = 2; k < CODE_W; k++)
            if (c[k]) s += int'(w[(k-2)*FNS_W +: FNS_W]);
        return s;
    endfunction

    initial begin
        int lat;
        logic [CODE_W-1:0] hc;
        logic              he;

        vecs[0] = '{"fib_50",     6'd50, 9'h1FF, W_FIB,  9'h148, 1'b0};
        vecs[1] = '{"fib_63",     6'd63, 9'h1FF, W_FIB,  9'h1A0, 1'b0};
        vecs[2] = '{"fib_0",      6'd0,  9'h1FF, W_FIB,  9'h000, 1'b0};
        vecs[3] = '{"fault_50",   6'd50, 9'h0FF, W_FIB,  9'h0F8, 1'b0};
        vecs[4] = '{"fault_60",   6'd60, 9'h0FF, W_FIB,  9'h0FF, 1'b1};
        vecs[5] = '{"zero_wt_5",  6'd5,  9'h1FF, W_ZERO, 9'h014, 1'b0};
        vecs[6] = '{"all_off_7",  6'd7,  9'h000, W_FIB,  9'h000, 1'b1};
        vecs[7] = '{"all_off_0",  6'd0,  9'h000, W_FIB,  9'h000, 1'b0};

        // Reset
        step(); step();
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_code",  32'(out_code),  32'd0);
        chk("rst_out_err",   32'(out_err),   32'd0);
        rst = 1'b0;
        step();

        foreach (vecs[i]) begin
            encode(vecs[i].data, vecs[i].en, vecs[i].w, lat);
            chk({vecs[i].name, "_lat"},  32'(lat),      32'(CODE_W));
            chk({vecs[i].name, "_code"}, 32'(out_code), 32'(vecs[i].exp_code));
            chk({vecs[i].name, "_err"},  32'(out_err),  32'(vecs[i].exp_err));
            consume();
            chk({vecs[i].name, "_drop"}, 32'({in_ready, out_valid}), 32'b10);
        end

        // Backpressure: output held, no accept while DONE
        encode(6'd50, 9'h1FF, W_FIB, lat);
        hc = out_code; he = out_err;
        in_valid = 1'b1; in_data = 6'd1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold", 32'({out_valid, in_ready, out_err, out_code}),
                32'({1'b1, 1'b0, 1'b0, 9'h148}));
        end
        in_valid = 1'b0;
        chk("bp_stable", 32'({he, hc}), 32'({1'b0, 9'h148}));
        consume();
        chk("bp_release", 32'({in_ready, out_valid}), 32'b10);

        // Reset mid-CONV discards the word
        in_data = 6'd50; en_flag = 9'h1FF; fns_w = W_FIB; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_idle", 32'({in_ready, out_valid}), 32'b10);
        hc = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) hc[0] = 1'b1;
        end
        chk("midrst_no_valid", 32'(hc[0]), 32'd0);
        encode(6'd63, 9'h1FF, W_FIB, lat);
        chk("midrst_next_code", 32'(out_code), 32'h1A0);
        chk("midrst_next_err",  32'(out_err),  32'd0);
        consume();

        // Round-trip against a decoder using the same enables and weights
        for (int i = 0; i < 24; i++) begin
            logic [DATA_W-1:0] d;
            logic [CODE_W-1:0] e;
            logic [WW-1:0]     w;
            d = DATA_W'($urandom_range(0, 63));
            e = (i % 3 == 0) ? 9'h1FF : CODE_W'($urandom_range(0, 511));
            w = (i % 2 == 0) ? W_FIB : W_ALT;
            encode(d, e, w, lat);
            chk("rt_disabled_zero", 32'(out_code & ~e), 32'd0);
            if (!out_err) chk("rt_decode", 32'(decode(out_code, w)), 32'(d));
            else if (e == 9'h1FF && w == W_FIB)
                chk("rt_full_never_err", 32'(out_err), 32'd0);
            consume();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fns_enc_seq.md
Name: fns_enc_seq

Overview:
- Sequential adaptive-FNS encoder: transmit-side counterpart of the 9-wire FNS decoder.
- Converts a binary data word into a CODE_W-bit Fibonacci-numeral codeword by greedy MSB-first subtraction of the per-wire weights, one wire per cycle.
- Honours en_flag, so disabled or faulty wires are driven 0 and carry no weight.
- Sits between the data source and the bus drivers. Valid/ready on both sides.

Parameters:
- CODE_W, 9: codeword width (wire count); bits 0 and 1 have fixed weight 1.
- DATA_W, 6: data word width.
- FNS_W, 7: width of each weight and of the residual; FNS_W >= DATA_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_data  in  DATA_W  binary word to encode.
- in_valid  in  1  in_data, en_flag and fns_w are valid.
- in_ready  out  1  encoder can accept a word.
- en_flag  in  CODE_W  per-wire enable; 0 means the wire is unused and forced 0.
- fns_w  in  (CODE_W-2)*FNS_W  weights of wires 2..CODE_W-1; slice k-2 is the weight of wire k.
- out_code  out  CODE_W  encoded codeword.
- out_err  out  1  residual was nonzero; word not representable with enabled wires.
- out_valid  out  1  out_code and out_err are valid.
- out_ready  in  1  consumer accepts the output.

Behaviour:
- Clocking: all state on the rising edge of clk. rst is synchronous, active-high, and has priority over everything.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_code=0, out_err=0; residual and index cleared.
- FSM states are IDLE, CONV and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register in_data (zero-extended to FNS_W) into the residual.
  - Snapshot en_flag and fns_w, clear the code register, set idx=CODE_W-1, go to CONV.
  - Inputs are ignored after the accept edge.
- CONV:
  - in_ready=0. Each cycle handles wire idx.
  - Weight w = 1 for idx<=1, otherwise the snapshot slice idx-2.
  - If en[idx] && residual>=w: code[idx]=1 and residual -= w. Otherwise code[idx]=0.
  - Compare and subtract are unsigned FNS_W-bit; no wrap is possible because subtraction only happens when residual>=w.
  - If idx==0, go to DONE at the end of this cycle and set out_err=(residual after this step != 0). Otherwise idx-1.
- DONE:
  - out_valid=1; out_code and out_err are held stable while out_ready=0.
  - On out_ready, go to IDLE and drop out_valid on the next cycle.
  - No accept is allowed in DONE.
- Latency: accept edge at cycle 0, out_valid=1 from cycle CODE_W. Throughput is one word per CODE_W+2 cycles when out_ready is tied high.
- Weight of 0 on an enabled wire: residual>=0 is always true, so the bit is set and the residual is unchanged. This is legal and is not flagged.
- Disabled wire: its bit is always 0, whatever the residual.
- All wires disabled: out_code=0 and out_err = (in_data!=0).
- rst during CONV or DONE: the word is discarded and the FSM returns to IDLE next cycle. No out_valid is emitted for it.
- in_valid held high continuously: one word is accepted per pass through IDLE. in_ready is 0 in CONV and DONE.
- Round-trip property: when out_err=0, decoding out_code with the same en_flag and weights returns in_data.

Test Plan:
- Reset: assert rst 2 cycles -> in_ready=1, out_valid=0, out_code=0, out_err=0.
- Basic encode: weights 2,3,5,8,13,21,34, en=0x1FF, in_data=50 -> out_code=0x148, out_err=0, out_valid exactly 9 cycles after accept. in_data=63 -> 0x1A0. in_data=0 -> 0x000.
- Faulty wire: en=0x0FF, in_data=50 -> out_code=0x0F8, out_err=0. en=0x0FF, in_data=60 -> out_code=0x0FF, out_err=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_code and out_err stable, in_ready=0. Raise out_ready -> in_ready=1 next cycle.
- Reset mid-CONV: assert rst 4 cycles after accept -> IDLE next cycle and no out_valid. The next word, in_data=63, encodes to 0x1A0.
- Randomized round-trip: random in_data, en_flag and Fibonacci weights; feed out_code to the FNS decoder -> equals in_data whenever out_err=0.
